// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its self-test sweep driver:
// operand width, opcode map and the sweep FSM encoding.
package alu_pkg;

    localparam int W = 4;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOTA = 4'd7;
    localparam logic [3:0] OP_NOTB = 4'd8;
    localparam logic [3:0] OP_NAND = 4'd9;
    localparam logic [3:0] OP_NOR  = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_HOLD,
        ST_DONE
    } sweep_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference model of the ALU; every result is taken mod 2^W.
// Division by zero yields all-ones, unknown opcodes yield zero.
module alu_golden
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   s,
    output logic [W-1:0] y
);

    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    always_comb begin
        y = '0;
        case (s)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = prod[W-1:0];
            OP_DIV:  y = (b == '0) ? '1 : a / b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NOTB: y = ~b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Self-test initiator: walks OP_FIRST..OP_LAST through an external ALU,
// compares each sampled result with alu_golden and streams it out valid/ready.
module alu_sweep_driver
    import alu_pkg::*;
#(
    parameter int         W        = alu_pkg::W,
    parameter logic [3:0] OP_FIRST = 4'd1,
    parameter logic [3:0] OP_LAST  = 4'd12,
    parameter int         SETTLE   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_s,
    input  logic [W-1:0] alu_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [3:0]   res_op,
    output logic [W-1:0] res_y,
    output logic         res_err,
    output logic [7:0]   mism_cnt,
    output logic         done
);

    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    sweep_state_e     state, state_n;
    logic [3:0]       op, op_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [W-1:0]     a_lat, a_lat_n;
    logic [W-1:0]     b_lat, b_lat_n;
    logic [W-1:0]     gold_y;

    logic             take_start, accept, cnt_last, capture, drive_n;
    logic             busy_n, res_valid_n, res_err_n, done_n;
    logic [W-1:0]     alu_a_n, alu_b_n, res_y_n;
    logic [3:0]       alu_s_n, res_op_n;
    logic [7:0]       mism_cnt_n;

    assign take_start = (state == ST_IDLE) && start;
    assign accept     = (state == ST_HOLD) && res_ready;
    assign cnt_last   = (cnt == CNT_LAST);
    assign capture    = (state == ST_DRIVE) && cnt_last;

    // The golden model sees the same latched operands and opcode the ALU is driven with.
    alu_golden #(.W(W)) u_golden (
        .a (a_lat),
        .b (b_lat),
        .s (op),
        .y (gold_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_DRIVE;
            ST_DRIVE: if (cnt_last) state_n = ST_HOLD;
            ST_HOLD:  if (res_ready) state_n = (op == OP_LAST) ? ST_DONE : ST_DRIVE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Next values of every registered output, derived from the next state so
    // that each output is a flop with no combinational path from the inputs.
    always_comb begin
        a_lat_n     = take_start ? a_in : a_lat;
        b_lat_n     = take_start ? b_in : b_lat;
        op_n        = op;
        if (take_start) begin
            op_n = OP_FIRST;
        end else if (accept && (op != OP_LAST)) begin
            op_n = op + 4'd1;
        end
        cnt_n       = ((state == ST_DRIVE) && !cnt_last) ? cnt + CNT_W'(1) : '0;

        drive_n     = (state_n == ST_DRIVE) || (state_n == ST_HOLD);
        alu_a_n     = drive_n ? a_lat_n : '0;
        alu_b_n     = drive_n ? b_lat_n : '0;
        alu_s_n     = drive_n ? op_n : 4'd0;

        busy_n      = (state_n != ST_IDLE);
        res_valid_n = (state_n == ST_HOLD);
        done_n      = (state_n == ST_DONE);

        res_y_n     = res_y;
        res_op_n    = res_op;
        res_err_n   = res_err;
        mism_cnt_n  = mism_cnt;
        if (take_start) begin
            mism_cnt_n = 8'd0;
        end
        if (capture) begin
            res_y_n   = alu_y;
            res_op_n  = op;
            res_err_n = (alu_y != gold_y);
            if (alu_y != gold_y) begin
                mism_cnt_n = sat_inc8(mism_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op        <= 4'd0;
            cnt       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= 4'd0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            res_y     <= '0;
            res_op    <= 4'd0;
            res_err   <= 1'b0;
            mism_cnt  <= 8'd0;
        end else begin
            op        <= op_n;
            cnt       <= cnt_n;
            a_lat     <= a_lat_n;
            b_lat     <= b_lat_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            alu_s     <= alu_s_n;
            busy      <= busy_n;
            res_valid <= res_valid_n;
            done      <= done_n;
            res_y     <= res_y_n;
            res_op    <= res_op_n;
            res_err   <= res_err_n;
            mism_cnt  <= mism_cnt_n;
        end
    end

endmodule

// File: doc/alu_sweep_driver.md
# alu_sweep_driver

Sequential initiator for the 4-bit combinational `alu`. On a `start` pulse it latches an operand pair and walks opcodes OP_FIRST..OP_LAST through the ALU. For each opcode it samples the ALU result, checks it against an internal golden model, and delivers the tagged result on a valid/ready stream. It sits in front of an `alu` instance as the hardware replacement for the hand-written opcode sweep, for on-chip self-test.

## Interface
- `W`, 4: operand/result width; must match the `alu` instance.
- `OP_FIRST`, 4'd1: first opcode swept.
- `OP_LAST`, 4'd12: last opcode swept; OP_FIRST ≤ OP_LAST.
- `SETTLE`, 1: cycles the ALU inputs are held before `alu_y` is sampled; ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin sweep; sampled only in IDLE.
- `a_in`, `b_in` in W: operands, latched on accepted `start`.
- `busy` out 1: high from the cycle after accepted `start` through the `done` cycle.
- `alu_a`, `alu_b` out W: operands to `alu`.
- `alu_s` out 4: opcode to `alu`.
- `alu_y` in W: result from `alu`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_op` out 4: opcode of the presented result.
- `res_y` out W: sampled ALU result.
- `res_err` out 1: `res_y` differs from golden.
- `mism_cnt` out 8: saturating count of mismatches in the current/last sweep.
- `done` out 1: one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, DRIVE, HOLD, DONE.
  - IDLE:
    - `start` latches `a_in`/`b_in`, sets op=OP_FIRST, clears `mism_cnt` and moves to DRIVE.
    - `alu_s`=0 and `alu_a`/`alu_b`=0 while in IDLE.
  - DRIVE:
    - Drives `alu_a`/`alu_b` from the latches and `alu_s`=op.
    - Settle counter runs 0..SETTLE-1.
    - On the last count, captures `alu_y` into `res_y`, the golden compare into `res_err`, and op into `res_op`, then moves to HOLD.
    - `mism_cnt` increments (saturating at 255) when `res_err` is set.
  - HOLD:
    - `res_valid`=1; ALU inputs stay driven.
    - On `res_valid && res_ready`: if op==OP_LAST, go to DONE; else op+1 and go to DRIVE (counter reset).
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. `res_*` are stable while `res_valid && !res_ready`.
- Golden model uses the `alu_pkg` opcodes, with all results taken mod 2^W:
  - 1 add: a+b.
  - 2 sub: a−b.
  - 3 mul: low W bits of a*b.
  - 4 div: a/b truncated; b==0 gives all-ones.
  - 5 and; 6 or; 7 ~a; 8 ~b; 9 nand; 10 nor; 11 xnor; 12 xor.
  - Any other opcode: expected 0.
- `rst` at any point, including mid-sweep or mid-handshake, returns to IDLE in the next cycle. A pending result is discarded.

## Timing
- Reset values: state IDLE; `busy`, `res_valid`, `res_err` and `done` 0; `res_op`, `res_y`, `alu_a`, `alu_b` and `alu_s` 0; `mism_cnt` 0. Operand latches are 0.
- `start` sampled at cycle 0:
  - `busy` goes high at cycle 1 and the ALU is driven from cycle 1.
  - First `res_valid` appears at cycle 1+SETTLE.
- Each opcode costs SETTLE+1 cycles when `res_ready`=1, plus one cycle per stalled cycle.
- The `done` cycle follows the final accepting cycle. `busy` is low and a new `start` is accepted the cycle after `done`.
- All outputs are registered; there is no combinational path from `res_ready` to `res_*`.

## Structure
- `alu_pkg` holds W and the opcode constants `OP_ADD`..`OP_XOR` (1..12).
- Sub-module `alu_golden` is a combinational (a, b, s) → expected model built from `alu_pkg`. It is reusable by the testbenches.
- The FSM, settle counter and op counter live in `alu_sweep_driver`. The `alu` itself is instantiated outside this block.

## Test plan
- Full sweep, a=5, b=3, SETTLE=1, `res_ready`=1, correct `alu`:
  - (op,y) sequence (1,8) (2,2) (3,15) (4,1) (5,1) (6,7) (7,10) (8,12) (9,14) (10,8) (11,9) (12,6).
  - `res_err` is always 0; `mism_cnt`=0; `done` at cycle 25.
- Backpressure: hold `res_ready`=0 for 3 cycles on op 4. `res_op`=4 and `res_y`=1 stay stable; op 5 is driven only after the accepting cycle.
- Div by zero, a=9, b=0: op 4 expects 15. A faulty `alu` returning 0 gives `res_err`=1 on op 4 only and `mism_cnt`=1.
- `start` pulsed during a sweep and `rst` asserted while in HOLD on op 7: the extra `start` has no effect. After `rst`, all outputs are 0 the next cycle, and a new `start` with a=2, b=2 sweeps from op 1 (y=4).
- SETTLE=3, a=15, b=1: first `res_valid` at cycle 4; op 1 y=0 (wrap); op 3 y=15; op 2 y=14.
- Stuck-at-zero `alu`, a=5, b=3 sweep: mismatch on every op except op 8? No — ~3=12, so `mism_cnt`=12; mismatches occur on all ops whose golden is nonzero.
